// File: rtl/traffic_interval_timer.sv
// Interval timer paired with the traffic-light controller: produces registered
// short (Ts) and long (Tl) expiry flags, restarting on i_St or any light-state change.
module traffic_interval_timer #(
  parameter int PRESCALE    = 10,
  parameter int SHORT_TICKS = 3,
  parameter int LONG_TICKS  = 8,
  parameter int CNT_W       = 8
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic [1:0]       i_G,
  input  logic             i_St,
  input  logic             i_hold,
  output logic             o_Ts,
  output logic             o_Tl,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_elapsed
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic [1:0] {
    RUN_SHORT,
    RUN_LONG,
    EXPIRED
  } state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    prescale_q, prescale_d;
  logic [CNT_W-1:0] elapsed_q, elapsed_d;
  logic [1:0]       g_prev_q, g_prev_d;
  logic             ts_q, ts_d;
  logic             tl_q, tl_d;
  logic             busy_q, busy_d;
  logic             restart;
  logic [CNT_W-1:0] elapsed_inc;

  assign restart     = i_St | (i_G != g_prev_q);
  assign elapsed_inc = elapsed_q + CNT_W'(1);

  always_comb begin
    state_d    = state_q;
    prescale_d = prescale_q;
    elapsed_d  = elapsed_q;
    g_prev_d   = i_G;

    if (restart) begin
      state_d    = RUN_SHORT;
      prescale_d = '0;
      elapsed_d  = '0;
    end else if (!i_hold && state_q != EXPIRED) begin
      if (prescale_q == PW'(PRESCALE - 1)) begin
        prescale_d = '0;
        elapsed_d  = elapsed_inc;
        // State moves on the same edge that elapsed reaches a threshold.
        if (elapsed_inc == CNT_W'(LONG_TICKS)) begin
          state_d = EXPIRED;
        end else if (elapsed_inc == CNT_W'(SHORT_TICKS)) begin
          state_d = RUN_LONG;
        end
      end else begin
        prescale_d = prescale_q + PW'(1);
      end
    end

    ts_d   = (state_d != RUN_SHORT);
    tl_d   = (state_d == EXPIRED);
    busy_d = (state_d != EXPIRED);
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q    <= RUN_SHORT;
      prescale_q <= '0;
      elapsed_q  <= '0;
      g_prev_q   <= '0;
      ts_q       <= 1'b0;
      tl_q       <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      prescale_q <= prescale_d;
      elapsed_q  <= elapsed_d;
      g_prev_q   <= g_prev_d;
      ts_q       <= ts_d;
      tl_q       <= tl_d;
      busy_q     <= busy_d;
    end
  end

  assign o_Ts      = ts_q;
  assign o_Tl      = tl_q;
  assign o_busy    = busy_q;
  assign o_elapsed = elapsed_q;

endmodule

// File: tb/tb_traffic_interval_timer.sv
// Self-checking bench for traffic_interval_timer: directed scenarios plus random
// stimulus checked against a count-of-running-cycles reference model.
module tb_traffic_interval_timer;

  localparam int PRE   = 2;
  localparam int SHORT = 3;
  localparam int LONG  = 8;
  localparam int CW    = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [1:0]    g = 2'b00;
  logic          st = 1'b0;
  logic          hold = 1'b0;
  logic          ts, tl, busy;
  logic [CW-1:0] elapsed;

  int tests = 0;
  int fails = 0;
  // Model: cycles spent counting since the last restart, saturating at full expiry.
  int          m_cnt = 0;
  logic [1:0]  m_gprev = 2'b00;

  traffic_interval_timer #(
    .PRESCALE(PRE), .SHORT_TICKS(SHORT), .LONG_TICKS(LONG), .CNT_W(CW)
  ) dut (
    .i_clk(clk), .i_reset_n(reset_n), .i_G(g), .i_St(st), .i_hold(hold),
    .o_Ts(ts), .o_Tl(tl), .o_busy(busy), .o_elapsed(elapsed)
  );

  always #5 clk = ~clk;

  function automatic logic [CW+2:0] model_vec();
    int e;
    e = m_cnt / PRE;
    return {(m_cnt >= SHORT * PRE), (m_cnt >= LONG * PRE), (m_cnt < LONG * PRE), CW'(e)};
  endfunction

  function automatic logic [CW+2:0] dut_vec();
    return {ts, tl, busy, elapsed};
  endfunction

  task automatic step(input logic rn, input logic [1:0] gv, input logic sv, input logic hv);
    reset_n = rn; g = gv; st = sv; hold = hv;
    @(posedge clk);
    if (!rn) begin
      m_cnt = 0; m_gprev = 2'b00;
    end else begin
      if (sv || gv != m_gprev) m_cnt = 0;
      else if (!hv && m_cnt < LONG * PRE) m_cnt++;
      m_gprev = gv;
    end
    #1;
  endtask

  task automatic test_reset();
    step(1'b0, 2'b00, 1'b0, 1'b0);
    step(1'b0, 2'b00, 1'b0, 1'b0);
    tests++;
    if (dut_vec() !== {1'b0, 1'b0, 1'b1, 8'd0}) begin
      fails++; $display("FAIL reset: got %h want %h", dut_vec(), {1'b0, 1'b0, 1'b1, 8'd0});
    end
  endtask

  task automatic test_free_run();
    logic [CW+2:0] exp;
    int e;
    for (int k = 1; k <= 26; k++) begin
      step(1'b1, 2'b00, 1'b0, 1'b0);
      e = (k / 2 > 8) ? 8 : k / 2;
      exp = {(k >= 6), (k >= 16), (k < 16), CW'(e)};
      tests++;
      if (dut_vec() !== exp) begin
        fails++; $display("FAIL free_run k=%0d: got %h want %h", k, dut_vec(), exp);
      end
    end
  endtask

  task automatic test_g_change();
    step(1'b1, 2'b00, 1'b1, 1'b0);
    for (int k = 1; k <= 10; k++) step(1'b1, 2'b00, 1'b0, 1'b0);
    for (int k = 1; k <= 18; k++) begin
      step(1'b1, 2'b01, 1'b0, 1'b0);
      tests++;
      if (dut_vec() !== model_vec() || ts !== (k >= 7) || tl !== (k >= 17)) begin
        fails++; $display("FAIL g_change k=%0d: got %h want %h", k, dut_vec(), model_vec());
      end
    end
  endtask

  task automatic test_start_expired();
    for (int k = 0; k < 20; k++) step(1'b1, 2'b01, 1'b0, 1'b0);
    tests++;
    if (tl !== 1'b1 || elapsed !== 8'd8) begin
      fails++; $display("FAIL pre_expired: got tl=%b el=%0d want tl=1 el=8", tl, elapsed);
    end
    step(1'b1, 2'b01, 1'b1, 1'b0);
    tests++;
    if (dut_vec() !== {1'b0, 1'b0, 1'b1, 8'd0}) begin
      fails++; $display("FAIL start_expired: got %h want %h", dut_vec(), {1'b0, 1'b0, 1'b1, 8'd0});
    end
    for (int k = 1; k <= 17; k++) begin
      step(1'b1, 2'b01, 1'b0, 1'b0);
      tests++;
      if (dut_vec() !== model_vec() || ts !== (k >= 6) || tl !== (k >= 16)) begin
        fails++; $display("FAIL start_seq k=%0d: got %h want %h", k, dut_vec(), model_vec());
      end
    end
  endtask

  task automatic test_hold();
    logic [CW-1:0] frozen;
    step(1'b1, 2'b01, 1'b1, 1'b0);
    frozen = '0;
    for (int k = 1; k <= 22; k++) begin
      step(1'b1, 2'b01, 1'b0, (k >= 3 && k <= 7));
      if (k == 3) frozen = elapsed;
      tests++;
      if (dut_vec() !== model_vec() || ts !== (k >= 11) || tl !== (k >= 21) ||
          (k >= 3 && k <= 7 && elapsed !== frozen)) begin
        fails++; $display("FAIL hold k=%0d: got %h want %h", k, dut_vec(), model_vec());
      end
    end
  endtask

  task automatic test_start_hold();
    step(1'b1, 2'b10, 1'b1, 1'b0);
    for (int k = 0; k < 9; k++) step(1'b1, 2'b10, 1'b0, 1'b0);
    step(1'b1, 2'b10, 1'b1, 1'b1);
    tests++;
    if (dut_vec() !== {1'b0, 1'b0, 1'b1, 8'd0}) begin
      fails++; $display("FAIL start_hold: got %h want %h", dut_vec(), {1'b0, 1'b0, 1'b1, 8'd0});
    end
    for (int k = 0; k < 5; k++) step(1'b1, 2'b10, 1'b0, 1'b1);
    tests++;
    if (elapsed !== 8'd0 || ts !== 1'b0) begin
      fails++; $display("FAIL hold_frozen: got el=%0d ts=%b want el=0 ts=0", elapsed, ts);
    end
    // Prescale must also have stayed frozen: one tick needs two more counting edges.
    step(1'b1, 2'b10, 1'b0, 1'b0);
    tests++;
    if (elapsed !== 8'd0) begin
      fails++; $display("FAIL hold_prescale: got el=%0d want 0", elapsed);
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 2'b11, 1'b1, 1'b0);
    for (int k = 0; k < 10; k++) step(1'b1, 2'b11, 1'b0, 1'b0);
    tests++;
    if (elapsed !== 8'd5) begin
      fails++; $display("FAIL mid_elapsed: got %0d want 5", elapsed);
    end
    step(1'b0, 2'b11, 1'b1, 1'b0);
    tests++;
    if (dut_vec() !== {1'b0, 1'b0, 1'b1, 8'd0}) begin
      fails++; $display("FAIL reset_mid: got %h want %h", dut_vec(), {1'b0, 1'b0, 1'b1, 8'd0});
    end
    for (int k = 1; k <= 7; k++) begin
      step(1'b1, 2'b00, 1'b0, 1'b0);
      tests++;
      if (ts !== (k >= 6) || dut_vec() !== model_vec()) begin
        fails++; $display("FAIL reset_release k=%0d: got %h want %h", k, dut_vec(), model_vec());
      end
    end
  endtask

  task automatic test_random();
    logic [1:0] gv;
    gv = g;
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 11) == 0) gv = 2'($urandom_range(0, 3));
      step(($urandom_range(0, 59) != 0), gv, ($urandom_range(0, 24) == 0),
           ($urandom_range(0, 4) == 0));
      tests++;
      if (dut_vec() !== model_vec()) begin
        fails++; $display("FAIL random k=%0d: got %h want %h", k, dut_vec(), model_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_g_change();
    test_start_expired();
    test_hold();
    test_start_hold();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/traffic_interval_timer.md
Name: traffic_interval_timer

Overview:
Interval timer that sits opposite the traffic-light sequential controller. It consumes the controller's light-state output and an explicit start strobe, and produces the short-interval (Ts) and long-interval (Tl) expiry flags the controller uses to advance through S0 (00), S1 (01), S2 (11) and S3 (10). Any change of controller state restarts the interval automatically, so the controller needs no separate timer-reset logic.

Parameters:
PRESCALE, 10, clock cycles per timer tick; must be >= 1.
SHORT_TICKS, 3, ticks until o_Ts asserts; must be >= 1.
LONG_TICKS, 8, ticks until o_Tl asserts; must satisfy SHORT_TICKS < LONG_TICKS < 2^CNT_W.
CNT_W, 8, width of the tick counter and of o_elapsed.

Ports:
i_clk  in  1  system clock; all logic samples on the rising edge.
i_reset_n  in  1  synchronous, active-low reset.
i_G  in  2  controller light-state code (00, 01, 11, 10).
i_St  in  1  explicit restart strobe, one cycle wide.
i_hold  in  1  freezes the count while high (maintenance/override).
o_Ts  out  1  short interval expired (registered).
o_Tl  out  1  long interval expired (registered).
o_busy  out  1  interval running, i.e. not expired.
o_elapsed  out  CNT_W  completed ticks since the last restart; saturates at LONG_TICKS.

Behaviour:
- States: RUN_SHORT (elapsed < SHORT_TICKS), RUN_LONG (SHORT_TICKS <= elapsed < LONG_TICKS), EXPIRED (elapsed == LONG_TICKS).
- Output decode, all registered: o_Ts = (state != RUN_SHORT); o_Tl = (state == EXPIRED); o_busy = (state != EXPIRED).
- Reset (i_reset_n low at an edge):
  - state = RUN_SHORT; prescale counter = 0; o_elapsed = 0.
  - o_Ts = 0; o_Tl = 0; o_busy = 1.
  - g_prev = 2'b00.
  - Reset counts as a restart, so timing begins on the first edge after release.
- g_prev register: loads i_G on every non-reset edge.
- Restart event = i_St OR (i_G != g_prev). On a restart edge:
  - prescale = 0; elapsed = 0; state = RUN_SHORT.
  - o_Ts = 0; o_Tl = 0; o_busy = 1.
- Priority, highest first: reset > restart > hold > count.
- Count (no restart, i_hold = 0, state != EXPIRED):
  - prescale increments each edge.
  - When prescale == PRESCALE-1, prescale wraps to 0 and elapsed increments.
  - The state and the flags update on the same edge that elapsed reaches SHORT_TICKS or LONG_TICKS.
- Latency: o_Ts rises exactly SHORT_TICKS*PRESCALE edges after the restart edge; o_Tl rises exactly LONG_TICKS*PRESCALE edges after it.
- Hold: i_hold = 1 freezes prescale, elapsed, state and outputs. Each held cycle delays expiry by exactly one cycle.
- EXPIRED: the counter stops, elapsed stays at LONG_TICKS, and o_Ts = o_Tl = 1 until the next restart or reset.
- PRESCALE = 1: elapsed increments on every counting edge.
- i_St held high for several cycles: the timer is re-restarted on each of those edges and counting begins the edge after i_St falls.
- An i_G change and i_St on the same edge form a single restart.
- Reset mid-interval: aborts the interval immediately; there is no carry-over of prescale or elapsed.

Test Plan:
(Bench overrides: PRESCALE=2, SHORT_TICKS=3, LONG_TICKS=8, i_G=00.)
1. Release reset, no other stimulus -> o_Ts rises at the 6th edge after release; o_Tl rises and o_busy falls at the 16th edge; o_elapsed holds at 8 for a further 10 cycles.
2. At edge 10 (state RUN_LONG), change i_G 00->01 -> next edge o_Ts=0 and o_elapsed=0; o_Ts re-asserts 6 edges later; o_Tl re-asserts 16 edges later.
3. Pulse i_St for one cycle while EXPIRED -> next edge o_Ts=0, o_Tl=0, o_busy=1; the full sequence repeats with 6/16-cycle latency.
4. Assert i_hold for 5 cycles starting at edge 3 after restart -> o_Ts at edge 11, o_Tl at edge 21; o_elapsed is constant throughout the hold.
5. Assert i_St and i_hold together mid-count -> restart is taken (o_elapsed=0); then with i_hold still high the count stays frozen at 0.
6. Drive i_reset_n low for one edge at o_elapsed=5 while i_St=1 -> all outputs at reset values; after release, o_Ts rises after exactly 6 edges.
